// File: rtl/clint_arb.sv
// Two-requester round-robin arbiter in front of a CLINT-style register window.
// One transaction in flight: accept in IDLE, access downstream in ISSUE, strobe response in RESP.
module clint_arb #(
  parameter int                DATA_W = 64,
  parameter int                ADDR_W = 64,
  parameter logic [ADDR_W-1:0] BASE   = 64'h0200_0000,
  parameter logic [ADDR_W-1:0] SPAN   = 64'h0001_0000,
  parameter int                TMO    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [1:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ready_o,
  output logic              m0_rsp_valid_o,
  output logic [DATA_W-1:0] m0_rsp_rdata_o,
  output logic              m0_rsp_err_o,
  input  logic              m1_valid_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [1:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ready_o,
  output logic              m1_rsp_valid_o,
  output logic [DATA_W-1:0] m1_rsp_rdata_o,
  output logic              m1_rsp_err_o,
  output logic              dn_valid_o,
  output logic [1:0]        dn_req_o,
  output logic [ADDR_W-1:0] dn_addr_o,
  output logic [1:0]        dn_size_o,
  output logic [DATA_W-1:0] dn_wdata_o,
  input  logic              dn_ready_i,
  input  logic [DATA_W-1:0] dn_rdata_i,
  input  logic [1:0]        dn_resp_i,
  output logic              busy_o
);

  localparam logic [1:0]    REQ_READ  = 2'b01;
  localparam logic [1:0]    REQ_WRITE = 2'b10;
  // One extra bit so BASE+SPAN at the top of the address space does not wrap.
  localparam logic [ADDR_W:0] WIN_LO   = {1'b0, BASE};
  localparam logic [ADDR_W:0] WIN_HI   = {1'b0, BASE} + {1'b0, SPAN};
  localparam logic [15:0]     TMO_LAST = 16'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                   state_q;
  logic                     gnt_q;
  logic                     prio_q;
  logic [1:0]               req_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [1:0]               size_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [15:0]              cnt_q;
  logic [1:0][DATA_W-1:0]   rdata_q;
  logic [1:0]               err_q;

  logic              any_vld, sel, accept, in_win;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie prio_q names the winner; a lone requester always wins.
  assign any_vld   = m0_valid_i | m1_valid_i;
  assign sel       = (m0_valid_i & m1_valid_i) ? prio_q : m1_valid_i;
  assign sel_write = sel ? m1_write_i : m0_write_i;
  assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
  assign sel_size  = sel ? m1_size_i  : m0_size_i;
  assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
  assign in_win    = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);
  assign accept    = (state_q == IDLE) & any_vld & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      req_q   <= 2'b00;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (any_vld) begin
          gnt_q   <= sel;
          prio_q  <= ~sel;
          req_q   <= sel_write ? REQ_WRITE : REQ_READ;
          addr_q  <= sel_addr;
          size_q  <= sel_size;
          wdata_q <= sel_wdata;
          cnt_q   <= '0;
          if (in_win) begin
            state_q <= ISSUE;
          end else begin
            rdata_q[sel] <= '0;
            err_q[sel]   <= 1'b1;
            state_q      <= RESP;
          end
        end
        ISSUE: begin
          if (dn_ready_i) begin
            rdata_q[gnt_q] <= (req_q == REQ_WRITE) ? '0 : dn_rdata_i;
            err_q[gnt_q]   <= |dn_resp_i;
            state_q        <= RESP;
          end else if (cnt_q == TMO_LAST) begin
            rdata_q[gnt_q] <= '0;
            err_q[gnt_q]   <= 1'b1;
            state_q        <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ready_o     = accept & ~sel;
  assign m1_ready_o     = accept &  sel;
  assign m0_rsp_valid_o = (state_q == RESP) & ~gnt_q;
  assign m1_rsp_valid_o = (state_q == RESP) &  gnt_q;
  assign m0_rsp_rdata_o = rdata_q[0];
  assign m1_rsp_rdata_o = rdata_q[1];
  assign m0_rsp_err_o   = err_q[0];
  assign m1_rsp_err_o   = err_q[1];
  assign dn_valid_o     = (state_q == ISSUE);
  assign dn_req_o       = req_q;
  assign dn_addr_o      = addr_q;
  assign dn_size_o      = size_q;
  assign dn_wdata_o     = wdata_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_clint_arb.sv
// Randomized bench for clint_arb against a transaction-level model of arbitration,
// window decode, downstream wait/timeout and per-requester response holding.
module tb_clint_arb;
  localparam int          DW = 64, AW = 64, TMO = 16;
  localparam logic [63:0] BASE = 64'h0200_0000, SPAN = 64'h0001_0000;
  localparam logic [1:0]  REQ_READ = 2'b01, REQ_WRITE = 2'b10;

  logic clk = 1'b0, rst = 1'b1;
  logic m0_valid_i = 0, m0_write_i = 0, m1_valid_i = 0, m1_write_i = 0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [1:0] m0_size_i = '0, m1_size_i = '0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic m0_ready_o, m0_rsp_valid_o, m0_rsp_err_o, m1_ready_o, m1_rsp_valid_o, m1_rsp_err_o;
  logic [DW-1:0] m0_rsp_rdata_o, m1_rsp_rdata_o;
  logic dn_valid_o, busy_o, dn_ready_i = 0;
  logic [1:0] dn_req_o, dn_size_o, dn_resp_i = '0;
  logic [AW-1:0] dn_addr_o;
  logic [DW-1:0] dn_wdata_o, dn_rdata_i = '0;

  int total = 0, bad = 0;
  int prio = 0;
  logic [DW-1:0] exp_rd [2];
  logic          exp_er [2];

  clint_arb #(.DATA_W(DW), .ADDR_W(AW), .BASE(BASE), .SPAN(SPAN), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid_i(m0_valid_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_size_i(m0_size_i), .m0_wdata_i(m0_wdata_i), .m0_ready_o(m0_ready_o),
    .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_rdata_o(m0_rsp_rdata_o), .m0_rsp_err_o(m0_rsp_err_o),
    .m1_valid_i(m1_valid_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_size_i(m1_size_i), .m1_wdata_i(m1_wdata_i), .m1_ready_o(m1_ready_o),
    .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_rdata_o(m1_rsp_rdata_o), .m1_rsp_err_o(m1_rsp_err_o),
    .dn_valid_o(dn_valid_o), .dn_req_o(dn_req_o), .dn_addr_o(dn_addr_o), .dn_size_o(dn_size_o),
    .dn_wdata_o(dn_wdata_o), .dn_ready_i(dn_ready_i), .dn_rdata_i(dn_rdata_i),
    .dn_resp_i(dn_resp_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic any_out();
    return |{m0_ready_o, m1_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_rsp_err_o, m1_rsp_err_o,
             m0_rsp_rdata_o, m1_rsp_rdata_o, dn_valid_o, dn_req_o, dn_addr_o, dn_size_o,
             dn_wdata_o, busy_o};
  endfunction

  task automatic set_m(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [1:0] s, input logic [DW-1:0] d);
    if (i == 0) begin m0_valid_i = v; m0_write_i = w; m0_addr_i = a; m0_size_i = s; m0_wdata_i = d; end
    else        begin m1_valid_i = v; m1_write_i = w; m1_addr_i = a; m1_size_i = s; m1_wdata_i = d; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_valid_i = 0; m1_valid_i = 0; dn_ready_i = 0;
    @(negedge clk);
    rst = 1'b0;
    prio = 0;
    exp_rd = '{default: '0};
    exp_er = '{default: 1'b0};
  endtask

  // Runs one transaction from a negedge with request inputs already set; reports what was seen.
  // The downstream answers on the w-th ISSUE cycle (0-based).
  task automatic run_txn(input bit keep, input int w, input logic [DW-1:0] rd, input logic [1:0] rsp,
                         output logic [1:0] rdy, output int dncnt, output int first_dn, output int lat,
                         output logic [1:0] rspv, output logic [DW-1:0] ordata, output logic oerr,
                         output logic [AW-1:0] oaddr, output logic [1:0] osize,
                         output logic [DW-1:0] owdata, output logic [1:0] oreq,
                         output bit unstable, output bit leak);
    #1;
    rdy = {m1_ready_o, m0_ready_o};
    dncnt = 0; first_dn = 0; lat = 0; rspv = 0; ordata = '0; oerr = 0;
    oaddr = '0; osize = '0; owdata = '0; oreq = '0; unstable = 0; leak = 0;
    @(negedge clk);
    if (!keep) begin m0_valid_i = 0; m1_valid_i = 0; end
    m0_addr_i = {$urandom, $urandom}; m1_addr_i = {$urandom, $urandom};
    m0_wdata_i = {$urandom, $urandom}; m1_wdata_i = {$urandom, $urandom};
    for (int c = 1; c <= TMO + 4; c++) begin
      if (m0_ready_o || m1_ready_o) leak = 1;
      if (dn_valid_o) begin
        if (dncnt == 0) begin
          first_dn = c; oaddr = dn_addr_o; osize = dn_size_o; owdata = dn_wdata_o; oreq = dn_req_o;
        end else if (dn_addr_o !== oaddr || dn_size_o !== osize || dn_wdata_o !== owdata || dn_req_o !== oreq)
          unstable = 1;
        if (dncnt == w) begin dn_ready_i = 1; dn_rdata_i = rd; dn_resp_i = rsp; end
        else begin dn_ready_i = 0; dn_rdata_i = {$urandom, $urandom}; dn_resp_i = 2'($urandom); end
        dncnt++;
      end else dn_ready_i = 0;
      if (m0_rsp_valid_o || m1_rsp_valid_o) begin
        rspv = {m1_rsp_valid_o, m0_rsp_valid_o};
        ordata = m0_rsp_valid_o ? m0_rsp_rdata_o : m1_rsp_rdata_o;
        oerr = m0_rsp_valid_o ? m0_rsp_err_o : m1_rsp_err_o;
        lat = c;
      end
      @(negedge clk);
      dn_ready_i = 0;
      if (lat != 0) break;
    end
  endtask

  logic [1:0] rdy, rspv, osize, oreq;
  int dncnt, first_dn, lat;
  logic [DW-1:0] ordata, owdata;
  logic [AW-1:0] oaddr;
  logic oerr;
  bit unstable, leak;

  task automatic test_reset();
    m0_valid_i = 1; m1_valid_i = 1; m0_addr_i = BASE; m1_addr_i = BASE;
    #2;
    total++; if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_outputs: got nonzero want all 0"); end
    do_reset();
  endtask

  task automatic test_basic_read();
    set_m(0, 1, 0, 64'h0200_BFF8, 2'd3, '0);
    run_txn(0, 0, 64'h1234, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (rdy !== 2'b01) begin bad++; $display("FAIL basic_ready: got %b want 01", rdy); end
    total++; if (first_dn !== 1 || dncnt !== 1) begin bad++; $display("FAIL basic_dn: got first=%0d cnt=%0d want 1/1", first_dn, dncnt); end
    total++; if (lat !== 2 || rspv !== 2'b01) begin bad++; $display("FAIL basic_rsp: got lat=%0d v=%b want 2/01", lat, rspv); end
    total++; if (ordata !== 64'h1234 || oerr !== 0) begin bad++; $display("FAIL basic_data: got %h/%b want 1234/0", ordata, oerr); end
    total++; if (oaddr !== 64'h0200_BFF8 || oreq !== REQ_READ || osize !== 2'd3) begin bad++; $display("FAIL basic_fields: got %h/%b/%0d", oaddr, oreq, osize); end
    prio = 1; exp_rd[0] = 64'h1234; exp_er[0] = 0;
  endtask

  task automatic test_rr();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      set_m(0, 1, 0, BASE + 64'(i * 8), 2'd3, '0);
      set_m(1, 1, 0, BASE + 64'(i * 8 + 4), 2'd2, '0);
      g = i % 2;
      run_txn(1, 0, d, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
      total++; if (rdy !== 2'(1 << g)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, rdy, 2'(1 << g)); end
      total++; if (rspv !== 2'(1 << g) || ordata !== d) begin bad++; $display("FAIL rr_rsp[%0d]: got %b/%h want %b/%h", i, rspv, ordata, 2'(1 << g), d); end
      total++; if (leak) begin bad++; $display("FAIL rr_ready_busy[%0d]: got ready while busy want none", i); end
      exp_rd[g] = d; exp_er[g] = 0;
    end
    m0_valid_i = 0; m1_valid_i = 0;
    prio = 0;
  endtask

  task automatic test_out_of_window();
    set_m(1, 1, 1, 64'h8000_0000, 2'd2, 64'hDEAD);
    run_txn(0, 0, 64'h5555, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (rdy !== 2'b10 || dncnt !== 0) begin bad++; $display("FAIL oow_issue: got rdy=%b dn=%0d want 10/0", rdy, dncnt); end
    total++; if (lat !== 1 || rspv !== 2'b10 || oerr !== 1 || ordata !== '0) begin bad++; $display("FAIL oow_rsp: got lat=%0d v=%b e=%b d=%h", lat, rspv, oerr, ordata); end
    prio = 0; exp_rd[1] = '0; exp_er[1] = 1;
  endtask

  task automatic test_timeout();
    set_m(0, 1, 0, BASE + 64'h10, 2'd3, '0);
    run_txn(0, TMO + 5, 64'h77, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (dncnt !== TMO || lat !== TMO + 1) begin bad++; $display("FAIL tmo_len: got dn=%0d lat=%0d want %0d/%0d", dncnt, lat, TMO, TMO + 1); end
    total++; if (oerr !== 1 || ordata !== '0 || rspv !== 2'b01) begin bad++; $display("FAIL tmo_rsp: got e=%b d=%h v=%b", oerr, ordata, rspv); end
    set_m(0, 1, 0, BASE + 64'h18, 2'd3, '0);
    run_txn(0, TMO - 1, 64'hABCD, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (dncnt !== TMO || oerr !== 0 || ordata !== 64'hABCD) begin bad++; $display("FAIL tmo_edge: got dn=%0d e=%b d=%h want %0d/0/abcd", dncnt, oerr, ordata, TMO); end
    prio = 1; exp_rd[0] = 64'hABCD; exp_er[0] = 0;
  endtask

  task automatic test_resp_err();
    set_m(0, 1, 0, BASE + SPAN - 64'h8, 2'd3, '0);
    run_txn(0, 2, 64'hFEED, 2'b01, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (oerr !== 1 || ordata !== 64'hFEED || dncnt !== 3) begin bad++; $display("FAIL resp_err: got e=%b d=%h dn=%0d want 1/feed/3", oerr, ordata, dncnt); end
    prio = 1; exp_rd[0] = 64'hFEED; exp_er[0] = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [1:0] vp, sz [2];
      logic wr [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2], rd;
      logic [1:0] rsp;
      logic [64:0] a65;
      int g, w, edn, elat;
      logic inwin, eerr;
      logic [DW-1:0] erd;
      vp = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        case ($urandom_range(0, 7))
          0: ad[m] = BASE - 64'h1;
          1: ad[m] = BASE + SPAN;
          2: ad[m] = BASE + SPAN - 64'h1;
          3: ad[m] = {$urandom, $urandom};
          default: ad[m] = BASE + 64'($urandom_range(0, 32'hFFFF));
        endcase
        wr[m] = 1'($urandom); sz[m] = 2'($urandom); wd[m] = {$urandom, $urandom};
        set_m(m, vp[m], wr[m], ad[m], sz[m], wd[m]);
      end
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3);
      rd = {$urandom, $urandom};
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      g = (vp == 2'b11) ? prio : (vp[1] ? 1 : 0);
      a65 = {1'b0, ad[g]};
      inwin = (a65 >= {1'b0, BASE}) && (a65 < {1'b0, BASE} + {1'b0, SPAN});
      if (!inwin)       begin edn = 0;   elat = 1;       eerr = 1;         erd = '0; end
      else if (w < TMO) begin edn = w+1; elat = w + 2;   eerr = (rsp != 0); erd = wr[g] ? '0 : rd; end
      else              begin edn = TMO; elat = TMO + 1; eerr = 1;         erd = '0; end
      run_txn(0, w, rd, rsp, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
      total++; if (rdy !== 2'(1 << g)) begin bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, rdy, 2'(1 << g)); end
      total++; if (dncnt !== edn || lat !== elat) begin bad++; $display("FAIL rnd_timing[%0d]: got dn=%0d lat=%0d want %0d/%0d", i, dncnt, lat, edn, elat); end
      total++; if (rspv !== 2'(1 << g) || oerr !== eerr || ordata !== erd) begin bad++; $display("FAIL rnd_rsp[%0d]: got v=%b e=%b d=%h want %b/%b/%h", i, rspv, oerr, ordata, 2'(1 << g), eerr, erd); end
      if (inwin) begin
        total++;
        if (oaddr !== ad[g] || osize !== sz[g] || owdata !== wd[g] || oreq !== (wr[g] ? REQ_WRITE : REQ_READ) || unstable)
          begin bad++; $display("FAIL rnd_dn_fields[%0d]: got %h/%0d/%h/%b unstable=%0d", i, oaddr, osize, owdata, oreq, unstable); end
      end
      prio = 1 - g; exp_rd[g] = erd; exp_er[g] = eerr;
      total++; if (busy_o !== 0 || m0_rsp_valid_o !== 0 || m1_rsp_valid_o !== 0) begin bad++; $display("FAIL rnd_idle[%0d]: got busy=%b v=%b%b want 0", i, busy_o, m1_rsp_valid_o, m0_rsp_valid_o); end
      total++;
      if (m0_rsp_rdata_o !== exp_rd[0] || m1_rsp_rdata_o !== exp_rd[1] || m0_rsp_err_o !== exp_er[0] || m1_rsp_err_o !== exp_er[1])
        begin bad++; $display("FAIL rnd_hold[%0d]: got %h/%b %h/%b want %h/%b %h/%b", i, m0_rsp_rdata_o, m0_rsp_err_o, m1_rsp_rdata_o, m1_rsp_err_o, exp_rd[0], exp_er[0], exp_rd[1], exp_er[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit strobe;
    @(negedge clk);
    set_m(0, 1, 0, BASE + 64'h40, 2'd3, '0);
    @(negedge clk);
    m0_valid_i = 0;
    total++; if (dn_valid_o !== 1) begin bad++; $display("FAIL rstmid_issue: got dn_valid=%b want 1", dn_valid_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (any_out() !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got nonzero want all 0"); end
    strobe = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (m0_rsp_valid_o || m1_rsp_valid_o) strobe = 1; end
    rst = 1'b0;
    prio = 0; exp_rd = '{default: '0}; exp_er = '{default: 1'b0};
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (m0_rsp_valid_o || m1_rsp_valid_o) strobe = 1; end
    total++; if (strobe) begin bad++; $display("FAIL rstmid_no_rsp: got strobe want none"); end
    set_m(0, 1, 0, BASE, 2'd3, '0);
    set_m(1, 1, 0, BASE + 64'h8, 2'd3, '0);
    run_txn(0, 0, 64'h99, 2'b00, rdy, dncnt, first_dn, lat, rspv, ordata, oerr, oaddr, osize, owdata, oreq, unstable, leak);
    total++; if (rdy !== 2'b01 || rspv !== 2'b01) begin bad++; $display("FAIL rstmid_tie: got rdy=%b v=%b want 01/01", rdy, rspv); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_rr();
    test_out_of_window();
    test_timeout();
    test_resp_err();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
